// File: rtl/seq_uart_reporter.sv
// seq_uart_reporter: converts a 16-bit value to decimal ASCII and sends it as "ddddd\r\n" over UART 8N1.
//   Ports: clk, rst (async, active high); num_in/num_valid/num_ready accept a value (ready only in IDLE);
//   tx serial output (idles high); busy high outside IDLE; drop_count saturating count of valids refused.
//   Macro LEADING_ZERO_SUPPRESS_EN: when defined, leading zero digits are skipped (0 is still sent as "0").
module seq_uart_reporter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num_in,
  input  logic        num_valid,
  output logic        num_ready,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_count
);
  typedef enum logic [2:0] {IDLE, CONVERT, LOAD, SEND, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] bin_q, bin_d, baud_q, baud_d;
  logic [19:0] bcd_q, bcd_d, adj, conv, dsh;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d, first;
  logic [9:0]  sh_q, sh_d;
  logic [7:0]  drop_q, drop_d, chr;
  logic        bit_done;
  // shift-add-3: bump every digit above 4 before the doubling shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++)
      adj[4*i +: 4] = bcd_q[4*i +: 4] > 4'd4 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  assign conv = {adj[18:0], bin_q[15]};
`ifdef LEADING_ZERO_SUPPRESS_EN
  // first character index taken from the final BCD result; the units digit is always sent
  assign first = conv[19:16] != 4'd0 ? 3'd0 : conv[15:12] != 4'd0 ? 3'd1 :
                 conv[11:8] != 4'd0 ? 3'd2 : conv[7:4] != 4'd0 ? 3'd3 : 3'd4;
`else
  assign first = 3'd0;
`endif
  // character index 0..4 are digits (most significant first), 5 is CR, 6 is LF
  assign dsh = bcd_q << {idx_q, 2'b00};
  assign chr = idx_q == 3'd5 ? 8'h0D : idx_q == 3'd6 ? 8'h0A : {4'h3, dsh[19:16]};
  assign bit_done = baud_q == 16'(CLKS_PER_BIT - 1);
  assign num_ready = state_q == IDLE;
  assign busy = !num_ready;
  // decoded from registers so reset drives tx high without waiting for a clock
  assign tx = state_q != SEND || sh_q[0];
  assign drop_count = drop_q;
  assign drop_d = num_valid && !num_ready && drop_q != 8'hFF ? drop_q + 8'd1 : drop_q;
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh_d = sh_q;
    baud_d = baud_q;
    case (state_q)
      IDLE: if (num_valid) begin
        state_d = CONVERT;
        bin_d = num_in;
        bcd_d = '0;
        cnt_d = '0;
      end
      CONVERT: begin
        bin_d = bin_q << 1;
        bcd_d = conv;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = LOAD;
          idx_d = first;
        end
      end
      LOAD: begin
        state_d = SEND;
        sh_d = {1'b1, chr, 1'b0};
        baud_d = '0;
        cnt_d = '0;
      end
      SEND: begin
        baud_d = baud_q + 16'd1;
        if (bit_done) begin
          baud_d = '0;
          sh_d = {1'b1, sh_q[9:1]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            state_d = idx_q == 3'd6 ? DONE : LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      sh_q <= '0;
      baud_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh_q <= sh_d;
      baud_q <= baud_d;
      drop_q <= drop_d;
    end
  end
endmodule

// File: tb/tb_seq_uart_reporter.sv
// tb_seq_uart_reporter: randomized bench for seq_uart_reporter against a cycle-exact model of the serial output.
module tb_seq_uart_reporter;
  localparam int C = 4;
  localparam int F = 10 * C + 1;
  logic        clk = 0, rst = 1, num_valid = 0;
  logic [15:0] num_in = 0;
  logic        num_ready, tx, busy;
  logic [7:0]  drop_count;
  int          total = 0, bad = 0, exp_drop = 0;
  always #5 clk = ~clk;
  seq_uart_reporter #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .num_in(num_in), .num_valid(num_valid),
    .num_ready(num_ready), .tx(tx), .busy(busy), .drop_count(drop_count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input logic [15:0] v, input int ndrop, input bit hold, input int abort_at);
    byte q[$];
    int slot[$];
    int n, len, nv, dg, p, j, r, b, pre0, busy_bad;
    bit lead, dv;
    logic e;
    logic [40:0] of, ef;
    lead = 1;
    for (int i = 0; i < 5; i++) begin
      dg = (int'(v) / (10 ** (4 - i))) % 10;
`ifdef LEADING_ZERO_SUPPRESS_EN
      if (dg == 0 && lead && i < 4) continue;
`endif
      lead = 0;
      q.push_back(byte'(48 + dg));
    end
    q.push_back(8'h0D);
    q.push_back(8'h0A);
    n = q.size();
    len = 18 + n * F - 1;
    for (int i = 0; i < ndrop; i++) slot.push_back(3 + i * 40 + int'($urandom_range(0, 20)));
    check("ready_before", num_ready, 1);
    num_in = v;
    num_valid = 1;
    step;
    nv = 0; pre0 = 0; busy_bad = 0;
    of = '0; ef = '0;
    for (int k = 1; k <= len; k++) begin
      dv = hold;
      foreach (slot[i]) if (slot[i] == k) dv = 1;
      num_valid = dv;
      num_in = 16'($urandom);
      if (dv) nv++;
      step;
      e = 1;
      p = k - 17; j = p / F; r = p % F; b = r / C;
      if (k >= 17 && j < n && r < 40) e = b == 0 ? 1'b0 : b == 9 ? 1'b1 : q[j][b-1];
      if (k == abort_at) begin
        check("pre_rst_tx", tx, e);
        rst = 1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", num_ready, 1);
        check("rst_drop", drop_count, 0);
        exp_drop = 0;
        num_valid = 0;
        return;
      end
      if (k < 17) begin
        if (tx !== 1'b1) pre0++;
      end else if (j < n) begin
        of[r] = tx;
        ef[r] = e;
        if (r == 40) check($sformatf("frame%0d_of_%0d", j, v), of, ef);
      end
      if (k < len && (busy !== 1'b1 || num_ready !== 1'b0)) busy_bad++;
    end
    num_valid = 0;
    check("pre_start_high", pre0, 0);
    check("busy_span", busy_bad, 0);
    check("end_ready", num_ready, 1);
    check("end_busy", busy, 0);
    exp_drop = exp_drop + nv > 255 ? 255 : exp_drop + nv;
    check("drop_count", drop_count, exp_drop);
  endtask
  initial begin
    int zeros;
    step;
    step;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_ready", num_ready, 1);
    check("reset_drop", drop_count, 0);
    rst = 0;
    zeros = 0;
    for (int i = 0; i < 100; i++) begin
      step;
      if (tx !== 1'b1 || busy !== 1'b0) zeros++;
    end
    check("idle_quiet", zeros, 0);
    txn(16'd12345, 0, 0, 0);
    txn(16'd65535, 0, 0, 0);
    txn(16'd0, 0, 0, 0);
    txn(16'd7, 0, 0, 0);
    txn(16'd12345, 3, 0, 0);
    for (int i = 0; i < 4; i++) txn(16'($urandom), 0, 0, 0);
    txn(16'd500, 0, 1, 0);
    txn(16'd3, 2, 0, 0);
    txn(16'd12345, 0, 0, 71);
    step;
    step;
    rst = 0;
    txn(16'd42, 0, 0, 0);
    txn(16'($urandom_range(0, 99)), 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_uart_reporter.md
SEQ_UART_REPORTER -- requirements
Module: seq_uart_reporter

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per UART bit (115200 baud at 50 MHz); legal range 4..65535.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: num_in  input  16  unsigned sequence value from the upstream sequence generator.
REQ-005 Port: num_valid  input  1  num_in is valid this cycle; single-cycle pulse or level.
REQ-006 Port: num_ready  output  1  block is able to accept num_in; high only in IDLE.
REQ-007 Port: tx  output  1  UART 8N1 serial output; idles high.
REQ-008 Port: busy  output  1  high in every state except IDLE.
REQ-009 Port: drop_count  output  8  saturating count of num_valid cycles that arrive while num_ready is low.

Function
REQ-010 The FSM SHALL have the states IDLE, CONVERT, LOAD, SEND and DONE.
REQ-011 In IDLE with num_valid=1, the block SHALL capture num_in and enter CONVERT on the same edge; that is the accept cycle.
REQ-012 CONVERT SHALL perform a sequential binary-to-BCD conversion into 5 digits (shift-add-3), one bit per cycle.
REQ-013 CONVERT SHALL last exactly 16 cycles; BCD width is 20 bits; no digit may exceed 9.
REQ-014 LOAD SHALL select the next character: ASCII 0x30+digit (most significant digit first), then 0x0D, then 0x0A.
REQ-015 SEND SHALL emit one 8N1 frame: start bit 0, data LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles.
REQ-016 The tx start bit for the first character SHALL begin the cycle after CONVERT completes (LOAD lasts 1 cycle).
REQ-017 Between characters the FSM SHALL pass through LOAD for exactly 1 cycle, with tx held high during that cycle.
REQ-018 After the stop bit of 0x0A the FSM SHALL enter DONE for 1 cycle, then IDLE; num_ready rises on IDLE entry.
REQ-019 The transaction length SHALL be 18 + 7 x (10 x CLKS_PER_BIT + 1) - 1 cycles for 7 characters, from the accept edge to IDLE re-entry.
REQ-020 num_valid while not in IDLE SHALL be ignored for data purposes and SHALL increment drop_count by 1 per cycle asserted.
REQ-021 drop_count SHALL saturate at 255 and SHALL NOT wrap.
REQ-022 num_in changes after the accept cycle SHALL NOT affect the transaction in progress.
REQ-023 The bit counter and character index SHALL be internal; the baud counter SHALL be at least 16 bits wide.

Reset
REQ-024 On rst=1, asynchronously: state=IDLE, tx=1, busy=0, num_ready=1, drop_count=0, and all counters and BCD registers cleared.
REQ-025 rst asserted mid-frame SHALL force tx=1 immediately; the partial character is abandoned and not resumed.
REQ-026 After rst deasserts, the first rising edge SHALL accept a pending num_valid.

Configuration
REQ-027 Macro LEADING_ZERO_SUPPRESS_EN SHALL control leading-zero handling.
REQ-028 With LEADING_ZERO_SUPPRESS_EN defined: leading zero digits are skipped, so LOAD starts at the first nonzero digit; value 0 sends a single "0".
- Character count is 3..7.
- Timing follows REQ-019 with 7 replaced by the actual count.
REQ-029 Without LEADING_ZERO_SUPPRESS_EN: all 5 digits are always sent (7 characters per value).

Verification
REQ-030 Reset check: assert rst -> tx=1, busy=0, num_ready=1, drop_count=0; deassert and idle 100 cycles -> tx stays 1.
REQ-031 Typical value: num_in=12345 pulsed 1 cycle, CLKS_PER_BIT=4 -> bytes 0x31 0x32 0x33 0x34 0x35 0x0D 0x0A.
- First start-bit falling edge exactly 17 cycles after the accept edge.
- Each bit exactly 4 cycles long.
REQ-032 Boundary values: num_in=65535 -> "65535\r\n"; num_in=0 -> "00000\r\n" without the macro and "0\r\n" with it.
- With the macro, num_in=7 -> "7\r\n".
REQ-033 Drops: during a transaction, pulse num_valid 3 times with different values -> drop_count=3; output bytes unchanged.
- Hold num_valid high for 300 busy cycles -> drop_count=255.
REQ-034 Reset mid-operation: assert rst during the 3rd data bit of the 2nd character -> tx=1 in the same cycle, state IDLE.
- After release, num_in=42 -> "00042\r\n" (without the macro), with correct framing.
